// File: rtl/regfile_write_arbiter_pkg.sv
// Shared core definitions for the register-file write path.
// Holds the register file geometry and the write-port arbiter grant encoding.
package regfile_write_arbiter_pkg;

  localparam int REGISTER_WIDTH = 32;
  localparam int REGISTER_DEPTH = 32;
  localparam int REG_ADDR_W     = $clog2(REGISTER_DEPTH);
  localparam int STARVE_CNT_W   = 4;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_WB   = 2'd1,
    GRANT_MC   = 2'd2
  } grant_e;

endpackage

// File: rtl/regfile_pending_scoreboard.sv
// Tracks registers whose value is still owed by the multi-cycle unit.
// One bit per architectural register; x0 never becomes pending.
module regfile_pending_scoreboard
  import regfile_write_arbiter_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      issue_valid_i,
  input  logic [REG_ADDR_W-1:0]     issue_address_i,
  output logic                      issue_ready_o,
  input  logic                      clear_valid_i,
  input  logic [REG_ADDR_W-1:0]     clear_address_i,
  output logic [REGISTER_DEPTH-1:0] pending_mask_o
);

  logic [REGISTER_DEPTH-1:0] pending_q, pending_d;
  logic                      clear_hit;
  logic                      issue_fire;

  // A result retiring to the same register this cycle frees the slot, so the
  // new issue may take it; the set below then keeps the bit owned.
  assign clear_hit     = clear_valid_i && (clear_address_i == issue_address_i);
  assign issue_ready_o = rst_n && ((issue_address_i == '0) ||
                                   !pending_q[issue_address_i] || clear_hit);
  assign issue_fire    = issue_valid_i && issue_ready_o;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    pending_d = pending_q;
    if (clear_valid_i) pending_d[clear_address_i] = 1'b0;
    if (issue_fire)    pending_d[issue_address_i] = 1'b1;
    pending_d[0] = 1'b0;
  end

  // NOTE: the mask is a plain flop vector, not a RAM, so it can and must be reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  assign pending_mask_o = pending_q;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port between writeback and the
// multi-cycle unit, with a bounded starvation counter and a registered port.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wb_valid,
  output logic                      wb_ready,
  input  logic [REG_ADDR_W-1:0]     wb_address,
  input  logic [REGISTER_WIDTH-1:0] wb_data,
  input  logic                      mc_valid,
  output logic                      mc_ready,
  input  logic [REG_ADDR_W-1:0]     mc_address,
  input  logic [REGISTER_WIDTH-1:0] mc_data,
  input  logic                      issue_valid,
  input  logic [REG_ADDR_W-1:0]     issue_address,
  output logic                      issue_ready,
  output logic [REGISTER_DEPTH-1:0] pending_mask,
  output logic                      registerport_write_enable,
  output logic [REG_ADDR_W-1:0]     registerport_write_address,
  output logic [REGISTER_WIDTH-1:0] registerport_write_data
);

  localparam logic [STARVE_CNT_W-1:0] STARVE_LIMIT_C = STARVE_CNT_W'(STARVE_LIMIT);

  grant_e                    grant;
  logic [STARVE_CNT_W-1:0]   starve_cnt_q, starve_cnt_d;
  logic                      wr_en_q, wr_en_d;
  logic [REG_ADDR_W-1:0]     wr_addr_q, wr_addr_d;
  logic [REGISTER_WIDTH-1:0] wr_data_q, wr_data_d;

  // Writeback normally wins; once mc has yielded STARVE_LIMIT times it goes first.
  always_comb begin
    grant = GRANT_NONE;
    if (rst) begin
      if (wb_valid && mc_valid)
        grant = (starve_cnt_q >= STARVE_LIMIT_C) ? GRANT_MC : GRANT_WB;
      else if (wb_valid)
        grant = GRANT_WB;
      else if (mc_valid)
        grant = GRANT_MC;
    end
  end

  assign wb_ready = (grant == GRANT_WB);
  assign mc_ready = (grant == GRANT_MC);

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!mc_valid || grant == GRANT_MC)
      starve_cnt_d = '0;
    else if (grant == GRANT_WB && starve_cnt_q != '1)
      starve_cnt_d = starve_cnt_q + 1'b1;
  end

  // Writes to x0 are accepted but never reach the register file.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = '0;
    wr_data_d = '0;
    unique case (grant)
      GRANT_WB: if (wb_address != '0) begin
        wr_en_d   = 1'b1;
        wr_addr_d = wb_address;
        wr_data_d = wb_data;
      end
      GRANT_MC: if (mc_address != '0) begin
        wr_en_d   = 1'b1;
        wr_addr_d = mc_address;
        wr_data_d = mc_data;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt_q <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign registerport_write_enable  = wr_en_q;
  assign registerport_write_address = wr_addr_q;
  assign registerport_write_data    = wr_data_q;

  regfile_pending_scoreboard u_pending (
    .clk             (clk),
    .rst_n           (rst),
    .issue_valid_i   (issue_valid),
    .issue_address_i (issue_address),
    .issue_ready_o   (issue_ready),
    .clear_valid_i   (mc_ready),
    .clear_address_i (mc_address),
    .pending_mask_o  (pending_mask)
  );

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the max consecutive cycles a waiting multi-cycle write yields to writeback (range 1..15).
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port wb_valid  input  1  writeback stage write request.
REQ-005 SHALL have port wb_ready  output  1  writeback request accepted this cycle.
REQ-006 SHALL have port wb_address  input  $clog2(REGISTER_DEPTH)  destination register.
REQ-007 SHALL have port wb_data  input  REGISTER_WIDTH  write value.
REQ-008 SHALL have port mc_valid  input  1  multi-cycle unit (mul/div) write request.
REQ-009 SHALL have port mc_ready  output  1  multi-cycle request accepted this cycle.
REQ-010 SHALL have port mc_address  input  $clog2(REGISTER_DEPTH)  destination register.
REQ-011 SHALL have port mc_data  input  REGISTER_WIDTH  write value.
REQ-012 SHALL have port issue_valid  input  1  multi-cycle op issued; mark destination pending.
REQ-013 SHALL have port issue_address  input  $clog2(REGISTER_DEPTH)  destination of issued op.
REQ-014 SHALL have port issue_ready  output  1  issue accepted (destination not already pending).
REQ-015 SHALL have port pending_mask  output  REGISTER_DEPTH  bit n set = register n awaits multi-cycle result.
REQ-016 SHALL have port registerport_write  MemoryInterface.write_out  --  register file write port (enable, address, data).

Function
REQ-017 Handshake SHALL complete on a requester when valid and ready are both high in the same cycle; ready SHALL be combinational from valid and state, never from the requester's own handshake.
REQ-018 Exactly one of wb_ready, mc_ready SHALL be high per cycle at most; if only one requester is valid it SHALL be granted.
REQ-019 Both valid, starve_cnt < STARVE_LIMIT: wb granted, starve_cnt increments.
REQ-020 Both valid, starve_cnt == STARVE_LIMIT: mc granted, wb_ready low.
REQ-021 starve_cnt SHALL clear on any mc handshake or any cycle mc_valid is low; width 4 bits, never wraps.
REQ-022 Write port outputs SHALL be registered: accepted request appears on enable/address/data exactly 1 cycle after handshake; enable low in all other cycles, address/data 0 when enable low.
REQ-023 Accepted write with address 0 SHALL complete the handshake but drive enable low (x0 suppression).
REQ-024 issue_ready SHALL be high iff pending_mask[issue_address] is 0 or issue_address is 0.
REQ-025 Issue handshake with nonzero address SHALL set pending_mask bit next cycle; address 0 SHALL not set any bit.
REQ-026 mc handshake SHALL clear pending_mask[mc_address] next cycle.
REQ-027 Same-cycle issue and mc handshake to the same address: set SHALL win (bit remains 1).
REQ-028 wb writes SHALL not read or modify pending_mask; WAW protection is the hazard unit's duty.
REQ-029 pending_mask[0] SHALL be constant 0.

Reset
REQ-030 rst low SHALL asynchronously force: enable 0, address 0, data 0, starve_cnt 0, pending_mask 0.
REQ-031 While rst low, wb_ready, mc_ready, issue_ready SHALL be 0.
REQ-032 Reset mid-operation SHALL drop any registered but unwritten output; requesters re-issue after reset.

Structure
REQ-033 REGISTER_WIDTH, REGISTER_DEPTH SHALL come from the shared core package; an arbiter grant enum (GRANT_NONE, GRANT_WB, GRANT_MC) SHALL be added there.
REQ-034 The pending-register scoreboard SHALL be a sub-module named regfile_pending_scoreboard; arbitration and output register stay in the top.

Verification
REQ-035 Only wb_valid, address 5, data 0xDEADBEEF -> wb_ready same cycle; next cycle enable=1, address=5, data=0xDEADBEEF.
REQ-036 wb_valid and mc_valid held high 6 cycles, STARVE_LIMIT=4 -> wb granted cycles 0-3, mc granted cycle 4, wb granted cycle 5.
REQ-037 mc write address 0, data 0x1234 -> mc_ready=1; next cycle enable=0.
REQ-038 Issue address 7; re-issue address 7 -> issue_ready=0; mc write to 7 -> pending_mask[7] clears next cycle, issue_ready=1.
REQ-039 Same-cycle issue 9 and mc handshake to 9 with bit 9 set -> pending_mask[9] stays 1.
REQ-040 Assert rst low asynchronously while enable=1 -> enable, pending_mask, starve_cnt 0 immediately, before next clk edge.
